dm_responder: RTL and testbench

Data-memory-side responder for the LSU's DM request interface. It accepts one load or one committed store at a time and drives a single-port synchronous SRAM macro with active-low controls. It returns load data with a fixed, parameterised latency and acknowledges each store with a one-cycle pulse. It sits between the LSU's DM port and the DM SRAM macro.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_responder.sv | 151 +++++++++++++++
 tb/tb_dm_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, strobe constants and the read-latency range check.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_RSP,
        WR_ACK
    } dm_state_e;

    localparam logic [3:0] STRB_NONE = 4'hF;
    localparam logic [3:0] STRB_WORD = 4'h0;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 2;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dm_responder.sv
// LSU-side responder driving a single-port active-low DM SRAM macro.
// Optional `DM_RANGE_CHK_EN adds a BASE_ADDR window check with acc_err.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ld_st_req_addr,
    input  logic              store_req_valid,
    output logic              store_req_ready,
    input  logic [3:0]        store_strb,
    input  logic [31:0]       store_data,
    output logic              store_data_valid,
    input  logic              load_req_valid,
    output logic              load_req_ready,
    output logic              load_data_valid,
    output logic [31:0]       load_data,
    output logic              dm_ceb,
    output logic [3:0]        dm_web,
    output logic [ADDR_W-1:0] dm_a,
    output logic [31:0]       dm_di,
    input  logic [31:0]       dm_do,
    output logic              acc_err
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    generate
        if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
            $error("dm_responder: RD_LAT must be within 1..4");
        end
    endgenerate

    dm_state_e        state;
    dm_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             idle;
    logic             st_hs;
    logic             ld_hs;
    logic             in_range;
    logic             rd_done;
    logic             unused_addr;

    assign unused_addr = ^{ld_st_req_addr[1:0], BASE_ADDR,
                           ld_st_req_addr[31:ADDR_W+2]};

`ifdef DM_RANGE_CHK_EN
    // A negative offset borrows into bit 32, so one shift covers both bounds.
    logic [32:0] offset;
    assign offset   = {1'b0, ld_st_req_addr} - {1'b0, BASE_ADDR};
    assign in_range = (offset >> (ADDR_W + 2)) == 33'd0;
`else
    assign in_range = 1'b1;
`endif

    assign idle    = (state == IDLE) && !rst;
    assign st_hs   = idle && store_req_valid;
    assign ld_hs   = idle && !store_req_valid && load_req_valid;
    assign rd_done = (state == RD_WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (st_hs) begin
                    state_nxt = WR_ACK;
                end else if (ld_hs) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RD_RSP;
                end
            end
            RD_RSP:  state_nxt = IDLE;
            WR_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        store_req_ready  = idle;
        load_req_ready   = idle && !store_req_valid;
        store_data_valid = (state == WR_ACK);
        load_data_valid  = (state == RD_RSP);
`ifdef DM_RANGE_CHK_EN
        acc_err = err_q && (store_data_valid || load_data_valid);
`else
        acc_err = 1'b0;
`endif
    end

    always_comb begin
        dm_ceb = 1'b1;
        dm_web = STRB_NONE;
        dm_a   = '0;
        dm_di  = '0;
        if (st_hs || ld_hs) begin
            dm_a   = ld_st_req_addr[ADDR_W+1:2];
            dm_ceb = !in_range;
        end
        if (st_hs) begin
            dm_di = store_data;
            if (in_range) begin
                dm_web = store_strb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld_hs) begin
            cnt <= CNT_INIT;
        end else if ((state == RD_WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (st_hs || ld_hs) begin
            err_q <= !in_range;
        end
    end

    // Out-of-window loads never touched the SRAM, so return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data <= '0;
        end else if (rd_done) begin
            load_data <= err_q ? 32'h0 : dm_do;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder with a behavioural DM SRAM model.
// Build with or without DM_RANGE_CHK_EN; expectations follow the macro.
module dm_sram_model #(
    parameter int AW     = 14,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          ceb,
    input  logic [3:0]    web,
    input  logic [AW-1:0] a,
    input  logic [31:0]   di,
    output logic [31:0]   dout
);
    logic [31:0] mem [2**AW];
    logic [31:0] pipe [RD_LAT];

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 32'h0;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (!ceb) begin
            pipe[0] <= mem[a];
            for (int b = 0; b < 4; b++)
                if (!web[b]) mem[a][8*b +: 8] <= di[8*b +: 8];
        end
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign dout = pipe[RD_LAT-1];
endmodule

module tb_dm_responder;
    localparam int          AW   = 14;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   ld_st_req_addr = '0;
    logic          store_req_valid = 1'b0;
    logic          store_req_ready;
    logic [3:0]    store_strb = 4'hF;
    logic [31:0]   store_data = '0;
    logic          store_data_valid;
    logic          load_req_valid = 1'b0;
    logic          load_req_ready;
    logic          load_data_valid;
    logic [31:0]   load_data;
    logic          dm_ceb;
    logic [3:0]    dm_web;
    logic [AW-1:0] dm_a;
    logic [31:0]   dm_di;
    logic [31:0]   dm_do;
    logic          acc_err;

    dm_responder #(.ADDR_W(AW), .RD_LAT(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .ld_st_req_addr(ld_st_req_addr),
        .store_req_valid(store_req_valid),
        .store_req_ready(store_req_ready),
        .store_strb(store_strb), .store_data(store_data),
        .store_data_valid(store_data_valid),
        .load_req_valid(load_req_valid),
        .load_req_ready(load_req_ready),
        .load_data_valid(load_data_valid), .load_data(load_data),
        .dm_ceb(dm_ceb), .dm_web(dm_web), .dm_a(dm_a),
        .dm_di(dm_di), .dm_do(dm_do), .acc_err(acc_err)
    );

    dm_sram_model #(.AW(AW), .RD_LAT(LAT)) sram (
        .clk(clk), .ceb(dm_ceb), .web(dm_web), .a(dm_a),
        .di(dm_di), .dout(dm_do)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t ld_q[$];
    exp_t st_q[$];
    logic [31:0] ref_mem [int];
    int cyc = 0;
    int vecs = 0;
    int errs = 0;
    int ld_pulses = 0, st_pulses = 0;
    int ld_hs_n = 0, st_hs_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit in_win(input logic [31:0] addr);
`ifdef DM_RANGE_CHK_EN
        logic [32:0] lim;
        lim = {1'b0, BASE} + 33'(4 * (2**AW));
        return ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < lim);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] addr);
        int idx = int'(addr[AW+1:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT pulses a response.
    always @(negedge clk) begin
        if (!rst && (load_data_valid || store_data_valid)) begin
            exp_t e;
            chk("pulse_excl", {31'b0, load_data_valid & store_data_valid}, 0);
            if (load_data_valid) begin
                ld_pulses++;
                if (ld_q.size() == 0) begin
                    chk("ld_unexpected", 0, 1);
                end else begin
                    e = ld_q.pop_front();
                    chk("ld_data", load_data, e.data);
                    chk("ld_err", {31'b0, acc_err}, {31'b0, e.err});
                    chk("ld_lat", cyc - e.cyc, LAT + 1);
                end
            end
            if (store_data_valid) begin
                st_pulses++;
                if (st_q.size() == 0) begin
                    chk("st_unexpected", 0, 1);
                end else begin
                    e = st_q.pop_front();
                    chk("st_err", {31'b0, acc_err}, {31'b0, e.err});
                    chk("st_lat", cyc - e.cyc, 1);
                end
            end
        end
    end

    task automatic wait_ready(input bit is_st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_st ? store_req_ready : load_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(is_st ? "st_ready_to" : "ld_ready_to", 0, 1);
    endtask

    task automatic note_store(input logic [31:0] addr,
                              input logic [3:0] strb,
                              input logic [31:0] data);
        exp_t e;
        logic [31:0] w;
        bit in = in_win(addr);
        st_hs_n++;
        chk("st_ceb", {31'b0, dm_ceb}, {31'b0, !in});
        if (in) begin
            chk("st_a", {18'b0, dm_a}, {18'b0, addr[AW+1:2]});
            chk("st_web", {28'b0, dm_web}, {28'b0, strb});
            w = ref_rd(addr);
            for (int b = 0; b < 4; b++)
                if (!strb[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[int'(addr[AW+1:2])] = w;
        end
        e.data = 32'h0;
        e.err  = !in;
        e.cyc  = cyc;
        st_q.push_back(e);
    endtask

    task automatic note_load(input logic [31:0] addr);
        exp_t e;
        bit in = in_win(addr);
        ld_hs_n++;
        chk("ld_ceb", {31'b0, dm_ceb}, {31'b0, !in});
        if (in) begin
            chk("ld_a", {18'b0, dm_a}, {18'b0, addr[AW+1:2]});
            chk("ld_web", {28'b0, dm_web}, 32'hF);
        end
        e.data = in ? ref_rd(addr) : 32'h0;
        e.err  = !in;
        e.cyc  = cyc;
        ld_q.push_back(e);
    endtask

    task automatic do_store(input logic [31:0] addr,
                            input logic [3:0] strb,
                            input logic [31:0] data);
        bit ok;
        ld_st_req_addr  = addr;
        store_strb      = strb;
        store_data      = data;
        store_req_valid = 1'b1;
        wait_ready(1'b1, ok);
        if (ok) note_store(addr, strb, data);
        @(posedge clk);
        #1 store_req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr);
        bit ok;
        ld_st_req_addr = addr;
        load_req_valid = 1'b1;
        wait_ready(1'b0, ok);
        if (ok) note_load(addr);
        @(posedge clk);
        #1 load_req_valid = 1'b0;
    endtask

    task automatic wait_ld_pulse(input string name,
                                 input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (load_data_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) chk(name, load_data, exp);
        else chk({name, "_to"}, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_st_rdy", {31'b0, store_req_ready}, 1);
        chk("rst_ld_rdy", {31'b0, load_req_ready}, 1);
        chk("rst_ceb", {31'b0, dm_ceb}, 1);
        chk("rst_web", {28'b0, dm_web}, 32'hF);
        chk("rst_ld_data", load_data, 0);
        chk("rst_pulses",
            {29'b0, store_data_valid, load_data_valid, acc_err}, 0);
        @(posedge clk);
        #1;

        // 1: full-word store then load back
        do_store(32'h0001_0040, 4'h0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_st_ack", {31'b0, store_data_valid}, 1);
        chk("t1_rdy_busy", {30'b0, store_req_ready, load_req_ready}, 0);
        @(posedge clk);
        #1;
        do_load(32'h0001_0040);
        wait_ld_pulse("t1_lw", 32'hDEADBEEF);

        // 2: byte-lane merge
        do_store(32'h0001_0080, 4'h0, 32'h11223344);
        do_store(32'h0001_0080, 4'b1101, 32'h0000AB00);
        do_load(32'h0001_0080);
        wait_ld_pulse("t2_sb", 32'h1122AB44);

        // 3: simultaneous store and load, store wins
        wait_ready(1'b1, ok);
        @(posedge clk);
        #1;
        ld_st_req_addr  = 32'h0001_00C0;
        store_strb      = 4'h0;
        store_data      = 32'hCAFEF00D;
        store_req_valid = 1'b1;
        load_req_valid  = 1'b1;
        @(negedge clk);
        chk("t3_st_rdy", {31'b0, store_req_ready}, 1);
        chk("t3_ld_rdy", {31'b0, load_req_ready}, 0);
        note_store(32'h0001_00C0, 4'h0, 32'hCAFEF00D);
        @(posedge clk);
        #1 store_req_valid = 1'b0;
        @(negedge clk);
        chk("t3_ld_rdy_ack", {31'b0, load_req_ready}, 0);
        @(negedge clk);
        chk("t3_ld_rdy_idle", {31'b0, load_req_ready}, 1);
        note_load(32'h0001_00C0);
        @(posedge clk);
        #1 load_req_valid = 1'b0;
        wait_ld_pulse("t3_lw", 32'hCAFEF00D);

        // 4: reset during RD_WAIT drops the response
        ld_st_req_addr = 32'h0001_0040;
        load_req_valid = 1'b1;
        wait_ready(1'b0, ok);
        @(posedge clk);
        #1 load_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_rdy", {30'b0, store_req_ready, load_req_ready}, 3);
        chk("t4_ld_data", load_data, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            chk("t4_no_pulse", {31'b0, load_data_valid}, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // 5: outside the window (aliases when the check is compiled out)
        do_store(32'h0000_0200, 4'h0, 32'h5A5A5A5A);
        do_load(32'h0000_0100);
`ifdef DM_RANGE_CHK_EN
        wait_ld_pulse("t5_lw_oor", 32'h0);
`else
        wait_ld_pulse("t5_lw_alias", ref_rd(32'h0001_0100));
`endif
        do_load(32'h0001_0200);
        // 6: alternating random store/load pairs
        for (int i = 0; i < 20; i++) begin
            a = BASE + 32'(4 * $urandom_range(0, 15));
            do_store(a, 4'($urandom_range(0, 15)), $urandom);
            a = BASE + 32'(4 * $urandom_range(0, 15));
            do_load(a);
        end

        wait_ready(1'b0, ok);
        repeat (LAT + 4) @(negedge clk);
        chk("ld_pulse_cnt", ld_pulses, ld_hs_n);
        chk("st_pulse_cnt", st_pulses, st_hs_n);
        chk("ld_q_empty", ld_q.size(), 0);
        chk("st_q_empty", st_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
